// File: rtl/tpu_fp_pkg.sv
// Shared FP32 sign-manipulation types and constants.
// NaN canonicalisation is enabled by defining FP_SIGN_NAN_CANON_EN.
package tpu_fp_pkg;

  typedef enum logic [1:0] {
    FP_PASS = 2'd0,
    FP_ABS  = 2'd1,
    FP_NEG  = 2'd2,
    FP_NABS = 2'd3
  } fp_mode_t;

  localparam int          FP32_SIGN_BIT  = 31;
  localparam logic [31:0] FP32_CANON_NAN = 32'h7FC0_0000;

  function automatic logic fp32_is_nan(
    input logic [31:0] w
  );
    return (w[30:23] == 8'hFF) && (w[22:0] != '0);
  endfunction

endpackage

// File: rtl/fp_sign_pipe_if.sv
// Valid/ready stream carrying mode, lane mask and packed FP32 lanes.
// Used by the testbench to drive and observe fp_sign_pipe.
interface fp_sign_pipe_if #(
  parameter int LANES = 4
) ();

  logic                  valid;
  logic                  ready;
  logic [1:0]            mode;
  logic [LANES-1:0]      mask;
  logic [32*LANES-1:0]   data;

  modport master (
    output valid,
    output mode,
    output mask,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  mode,
    input  mask,
    input  data,
    output ready
  );

endinterface

// File: rtl/fp_sign_lane.sv
// Single-lane FP32 sign operation (PASS/ABS/NEG/NABS).
// FP_SIGN_NAN_CANON_EN forces enabled NaN lanes to the canonical quiet NaN.
module fp_sign_lane
  import tpu_fp_pkg::*;
(
  input  logic [31:0] word_i,
  input  fp_mode_t    mode_i,
  input  logic        en_i,
  output logic [31:0] word_o
);

  always_comb begin
    word_o = word_i;
    if (en_i) begin
      unique case (mode_i)
        FP_ABS:  word_o[FP32_SIGN_BIT] = 1'b0;
        FP_NEG:  word_o[FP32_SIGN_BIT] = ~word_i[FP32_SIGN_BIT];
        FP_NABS: word_o[FP32_SIGN_BIT] = 1'b1;
        default: word_o = word_i;
      endcase
`ifdef FP_SIGN_NAN_CANON_EN
      if (fp32_is_nan(word_i)) begin
        word_o = FP32_CANON_NAN;
      end
`endif
    end
  end

endmodule

// File: rtl/fp_sign_pipe.sv
// LANES-wide FP32 sign pipeline, STAGES deep, with a global stall.
// Optional NaN canonicalisation via FP_SIGN_NAN_CANON_EN (see fp_sign_lane).
module fp_sign_pipe
  import tpu_fp_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          in_mode,
  input  logic [LANES-1:0]    in_mask,
  input  logic [32*LANES-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [32*LANES-1:0] out_data
);

  localparam int W = 32 * LANES;

  logic [W-1:0]      res;
  logic              stall;
  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] vld_d;
  logic [W-1:0]      dat_q [STAGES];
  logic [W-1:0]      dat_d [STAGES];

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    fp_sign_lane u_lane (
      .word_i (in_data[32*i +: 32]),
      .mode_i (fp_mode_t'(in_mode)),
      .en_i   (in_mask[i]),
      .word_o (res[32*i +: 32])
    );
  end

  // The whole pipe freezes when the output is held; bubbles
  // move forward only while the output side is draining.
  assign stall    = vld_q[STAGES-1] & ~out_ready;
  assign in_ready = ~stall;

  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    if (!stall) begin
      vld_d[0] = in_valid;
      dat_d[0] = res;
      for (int s = 1; s < STAGES; s++) begin
        vld_d[s] = vld_q[s-1];
        dat_d[s] = dat_q[s-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      for (int s = 0; s < STAGES; s++) begin
        dat_q[s] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      for (int s = 0; s < STAGES; s++) begin
        dat_q[s] <= dat_d[s];
      end
    end
  end

  assign out_valid = vld_q[STAGES-1];
  assign out_data  = dat_q[STAGES-1];

endmodule

// File: tb/tb_fp_sign_pipe.sv
// Scoreboard bench for fp_sign_pipe (LANES=4, STAGES=2) plus a
// STAGES=1..4 latency sweep on single-lane instances.
module tb_fp_sign_pipe;
  import tpu_fp_pkg::*;

  localparam int LANES  = 4;
  localparam int STAGES = 2;
  localparam int W      = 32 * LANES;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fp_sign_pipe_if #(.LANES(LANES)) in_if ();
  fp_sign_pipe_if #(.LANES(LANES)) out_if ();

  fp_sign_pipe #(.LANES(LANES), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_if.valid),
    .in_ready  (in_if.ready),
    .in_mode   (in_if.mode),
    .in_mask   (in_if.mask),
    .in_data   (in_if.data),
    .out_valid (out_if.valid),
    .out_ready (out_if.ready),
    .out_data  (out_if.data)
  );

  // latency sweep instances
  logic        sw_valid;
  logic [1:0]  sw_mode;
  logic [31:0] sw_data;
  logic        sw_ir [1:4];
  logic        sw_ov [1:4];
  logic [31:0] sw_od [1:4];

  for (genvar s = 1; s <= 4; s++) begin : g_sw
    fp_sign_pipe #(.LANES(1), .STAGES(s)) u_sw (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (sw_valid),
      .in_ready  (sw_ir[s]),
      .in_mode   (sw_mode),
      .in_mask   (1'b1),
      .in_data   (sw_data),
      .out_valid (sw_ov[s]),
      .out_ready (1'b1),
      .out_data  (sw_od[s])
    );
  end

  typedef struct {
    logic [W-1:0] exp;
    int           cyc;
    bit           lat;
  } exp_t;

  exp_t         q [$];
  exp_t         e;
  int           n_cmp = 0;
  int           n_err = 0;
  int           cyc   = 0;
  logic [W-1:0] cur_exp;
  bit           cur_lat;
  logic [W-1:0] held;
  bit           held_v;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name,
                       input logic [W-1:0] act,
                       input logic [W-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // monitor: pop/compare outputs, then record accepted inputs
  always @(negedge clk) begin
    if (rst) begin
      held_v = 1'b0;
    end else begin
      if (out_if.valid) begin
        if (held_v) check("hold_stable", out_if.data, held);
        if (!out_if.ready) begin
          check("in_ready_stall", W'(in_if.ready), '0);
          held   = out_if.data;
          held_v = 1'b1;
        end else begin
          held_v = 1'b0;
          if (q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_out: got %h expected none", out_if.data);
          end else begin
            e = q.pop_front();
            check("data", out_if.data, e.exp);
            if (e.lat) check("latency", W'(cyc - e.cyc), W'(STAGES));
          end
        end
      end else begin
        held_v = 1'b0;
      end
      if (in_if.valid && in_if.ready) q.push_back('{cur_exp, cyc, cur_lat});
    end
  end

  task automatic send(input logic [1:0] m, input logic [3:0] k,
                      input logic [W-1:0] d, input logic [W-1:0] x,
                      input bit lat);
    int t;
    in_if.mode  = m;
    in_if.mask  = k;
    in_if.data  = d;
    cur_exp     = x;
    cur_lat     = lat;
    in_if.valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!in_if.ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_if.ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
    end
    @(posedge clk);
    #1;
    in_if.valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 40) begin
      @(posedge clk);
      t++;
    end
    if (q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] bdat(input int i);
    logic [W-1:0] r;
    for (int j = 0; j < LANES; j++) begin
      r[32*j +: 32] = 32'h3F80_0000 + 32'(i * 16 + j);
    end
    return r;
  endfunction

  localparam logic [W-1:0] SIGNS = {4{32'h8000_0000}};

  int first [1:4];

  initial begin
    rst          = 1'b1;
    in_if.valid  = 1'b0;
    in_if.mode   = 2'd0;
    in_if.mask   = '0;
    in_if.data   = '0;
    out_if.ready = 1'b1;
    cur_exp      = '0;
    cur_lat      = 1'b0;
    sw_valid     = 1'b0;
    sw_mode      = 2'd0;
    sw_data      = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", W'(out_if.valid), '0);
    check("rst_out_data", out_if.data, '0);
    check("rst_in_ready", W'(in_if.ready), W'(1));
    rst = 1'b0;
    @(posedge clk);
    #1;

    send(FP_ABS, 4'hF,
         {32'hC060_0000, 32'h4060_0000, 32'h8000_0000, 32'h0000_0000},
         {32'h4060_0000, 32'h4060_0000, 32'h0000_0000, 32'h0000_0000}, 1);
    drain();
    send(FP_NEG, 4'b0101,
         {4{32'h4060_0000}},
         {32'h4060_0000, 32'hC060_0000, 32'h4060_0000, 32'hC060_0000}, 1);
    drain();
    send(FP_PASS, 4'hF,
         {32'hFF80_0000, 32'h7F80_0000, 32'h0000_0001, 32'h8000_0001},
         {32'hFF80_0000, 32'h7F80_0000, 32'h0000_0001, 32'h8000_0001}, 1);
    send(FP_ABS, 4'h0,
         {32'h8000_0000, 32'hBF80_0000, 32'hFF80_0000, 32'h8000_0001},
         {32'h8000_0000, 32'hBF80_0000, 32'hFF80_0000, 32'h8000_0001}, 0);
    send(FP_NEG, 4'hF,
         {32'h8000_0000, 32'h7F80_0000, 32'h0040_0000, 32'h3F80_0000},
         {32'h0000_0000, 32'hFF80_0000, 32'h8040_0000, 32'hBF80_0000}, 0);
    send(FP_ABS, 4'b1010,
         {32'hBF80_0000, 32'hBF80_0000, 32'hFF80_0000, 32'hFF80_0000},
         {32'h3F80_0000, 32'hBF80_0000, 32'h7F80_0000, 32'hFF80_0000}, 0);
    drain();

    // 8-deep burst with a 3-cycle output stall in the middle
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          send(FP_NEG, 4'hF, bdat(i), bdat(i) ^ SIGNS, 0);
        end
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        out_if.ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        out_if.ready = 1'b1;
      end
    join
    drain();

    // reset with two transactions in flight
    send(FP_PASS, 4'hF, {4{32'h1111_1111}}, {4{32'h1111_1111}}, 0);
    send(FP_PASS, 4'hF, {4{32'h2222_2222}}, {4{32'h2222_2222}}, 0);
    rst = 1'b1;
    q.delete();
    #1;
    check("midrst_out_valid", W'(out_if.valid), '0);
    check("midrst_out_data", out_if.data, '0);
    check("midrst_in_ready", W'(in_if.ready), W'(1));
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
`ifdef FP_SIGN_NAN_CANON_EN
    send(FP_NABS, 4'hF,
         {32'h7F80_0001, 32'h0000_0000, 32'h3F80_0000, 32'h7FFF_FFFF},
         {32'h7FC0_0000, 32'h8000_0000, 32'hBF80_0000, 32'h7FC0_0000}, 1);
`else
    send(FP_NABS, 4'hF,
         {32'h7F80_0001, 32'h0000_0000, 32'h3F80_0000, 32'h7FFF_FFFF},
         {32'hFF80_0001, 32'h8000_0000, 32'hBF80_0000, 32'hFFFF_FFFF}, 1);
`endif
    drain();

    // latency sweep over STAGES 1..4
    for (int s = 1; s <= 4; s++) first[s] = 0;
    sw_mode  = FP_NABS;
    sw_data  = 32'h7F80_0001;
    sw_valid = 1'b1;
    @(posedge clk);
    #1;
    sw_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      for (int s = 1; s <= 4; s++) begin
        if (sw_ov[s] && first[s] == 0) begin
          first[s] = k;
`ifdef FP_SIGN_NAN_CANON_EN
          check("sweep_data", W'(sw_od[s]), W'(32'h7FC0_0000));
`else
          check("sweep_data", W'(sw_od[s]), W'(32'hFF80_0001));
`endif
        end
      end
    end
    for (int s = 1; s <= 4; s++) begin
      check("sweep_latency", W'(first[s]), W'(s));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
